// File: rtl/fetch_step_controller_pkg.sv
// rtl/fetch_step_controller_pkg.sv - shared FSM encodings and default timing for fetch_step_controller
package fetch_step_controller_pkg;

   localparam logic [0:0] ST_STOPPED = 1'b0;
   localparam logic [0:0] ST_RUNNING = 1'b1;

   // Defaults assume a 100 MHz board clock: 10 ms debounce, 1 Hz auto-run.
   localparam int DEBOUNCE_CYCLES_DEF = 1000000;
   localparam int RUN_PERIOD_DEF      = 100000000;

endpackage

// File: rtl/fetch_step_controller_btn_debounce_pulse.sv
// rtl/fetch_step_controller_btn_debounce_pulse.sv - button synchronizer, debouncer and press pulse
module btn_debounce_pulse
   import fetch_step_controller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_press
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]      r_sync;
   logic [1:0]      r_vld;
   logic            r_armed;
   logic [DB_W-1:0] r_cnt;
   logic            r_stable;
   logic            r_stable_d;
   logic            r_press;
   logic            w_differ;

   assign w_differ = r_sync[1] != r_stable;
   assign o_press  = r_press;

   // r_armed blocks a button held through reset until it has been seen released.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync     <= '0;
         r_vld      <= '0;
         r_armed    <= 1'b0;
         r_cnt      <= '0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_press    <= 1'b0;
      end else begin
         r_sync     <= {r_sync[0], i_btn};
         r_vld      <= {r_vld[0], 1'b1};
         if (r_vld[1] && !r_sync[1]) begin
            r_armed <= 1'b1;
         end
         if (!w_differ) begin
            r_cnt <= '0;
         end else if (r_cnt == DB_LAST) begin
            r_cnt    <= '0;
            r_stable <= r_sync[1];
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_stable_d <= r_stable;
         r_press    <= r_stable & ~r_stable_d & r_armed;
      end
   end

endmodule

// File: rtl/fetch_step_controller.sv
// rtl/fetch_step_controller.sv - single-step / auto-run fetch-advance enable with fetch counter
module fetch_step_controller
   import fetch_step_controller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int RUN_PERIOD      = RUN_PERIOD_DEF,
   parameter int CNT_W           = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             BtnStep,
   input  logic             BtnRun,
   output logic             FetchEn,
   output logic             Running,
   output logic [CNT_W-1:0] FetchCount
);

   localparam int               DIV_W    = $clog2(RUN_PERIOD);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_PERIOD - 1);

   logic             w_step_press;
   logic             w_run_press;
   logic             w_div_wrap;
   logic [0:0]       r_state;
   logic [DIV_W-1:0] r_div;
   logic             r_fetch_en;
   logic [CNT_W-1:0] r_fetch_cnt;

   btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
      .i_clk   (Clk),
      .i_rst_n (Reset),
      .i_btn   (BtnStep),
      .o_press (w_step_press)
   );

   btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
      .i_clk   (Clk),
      .i_rst_n (Reset),
      .i_btn   (BtnRun),
      .o_press (w_run_press)
   );

   assign w_div_wrap = (r_state == ST_RUNNING) && (r_div == DIV_LAST);
   assign FetchEn    = r_fetch_en;
   assign Running    = r_state[0];
   assign FetchCount = r_fetch_cnt;

   // A run press outranks a simultaneous step press; the guard on r_fetch_en keeps pulses single-cycle.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state     <= ST_STOPPED;
         r_div       <= '0;
         r_fetch_en  <= 1'b0;
         r_fetch_cnt <= '0;
      end else begin
         r_fetch_cnt <= r_fetch_cnt + CNT_W'(r_fetch_en);
         case (r_state)
            ST_STOPPED: begin
               r_div <= '0;
               if (w_run_press) begin
                  r_state    <= ST_RUNNING;
                  r_fetch_en <= 1'b0;
               end else begin
                  r_fetch_en <= w_step_press & ~r_fetch_en;
               end
            end
            default: begin
               r_fetch_en <= w_div_wrap & ~r_fetch_en;
               if (w_run_press) begin
                  r_state <= ST_STOPPED;
                  r_div   <= '0;
               end else if (w_div_wrap) begin
                  r_div <= '0;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_step_controller.md
Name: fetch_step_controller

Overview:
- Generates the fetch-advance enable for the instruction fetch unit, so instructions shown on the seven-segment display can be walked through one at a time.
- Has two modes:
  - Single-step: one fetch per debounced board-button press.
  - Auto-run: one fetch every RUN_PERIOD clocks.
- Sits directly upstream of the fetch unit in the top level and drives its fetch/PC-advance enable.
- Also exports a fetch counter and a run flag for status LEDs.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronized button must hold a new level before it is accepted (10 ms at 100 MHz).
- RUN_PERIOD, 100000000: clocks between FetchEn pulses in auto-run (1 Hz at 100 MHz); minimum 2.
- CNT_W, 16: width of FetchCount.

Ports:
- Clk, input, 1: single system clock; all state is on the rising edge.
- Reset, input, 1: asynchronous, active-low reset (asserted when 0).
- BtnStep, input, 1: raw asynchronous step pushbutton, active-high.
- BtnRun, input, 1: raw asynchronous run/stop pushbutton, active-high; each accepted press toggles the mode.
- FetchEn, output, 1: one-cycle fetch-advance pulse to the fetch unit.
- Running, output, 1: 1 while in auto-run.
- FetchCount, output, CNT_W: number of FetchEn pulses issued, modulo 2^CNT_W.

Behaviour:
- Reset (Reset=0, asynchronous):
  - All flops clear: synchronizers, debounce counters, stable levels, press pulses, FSM, divider.
  - Outputs: FetchEn=0, Running=0, FetchCount=0. State = STOPPED.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter increments on each edge where the synchronized level differs from the stable level. It clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the levels still differing, the stable level takes the synchronized value and the counter clears.
  - Press is a registered one-cycle pulse on the stable level's 0->1 transition. Releases generate nothing.
- Latency: counting the first edge that samples a held button high as edge 0, the stable level updates at edge DEBOUNCE_CYCLES+1 and press at edge DEBOUNCE_CYCLES+2. In STOPPED, FetchEn is high after edge DEBOUNCE_CYCLES+3 for exactly one cycle.
- Glitch rejection: a high shorter than DEBOUNCE_CYCLES synchronized cycles produces no press.
- Holding a button produces exactly one press.
- FSM states, 2: STOPPED and RUNNING.
- STOPPED:
  - A step press makes FetchEn=1 on the next edge.
  - A run press moves to RUNNING and clears the divider.
  - If step and run presses occur in the same cycle, run wins and the step is dropped.
- RUNNING:
  - Divider counts 0..RUN_PERIOD-1 and wraps.
  - FetchEn=1 for one cycle on the edge after the divider equals RUN_PERIOD-1.
  - The first pulse comes RUN_PERIOD edges after Running rises, then one every RUN_PERIOD edges.
  - A run press returns to STOPPED; the divider stops and clears. A pulse already registered on that same edge still completes.
  - Step presses are ignored.
- Running is registered and equals (state == RUNNING).
- FetchCount increments on the edge after each FetchEn pulse and wraps from 2^CNT_W-1 to 0.
- FetchEn is never high for two consecutive cycles.
- Reset mid-operation: outputs drop to their reset values immediately (asynchronously). After Reset releases, the block is in STOPPED and a still-held button must first be released and then pressed again before it counts.

Decomposition:
- Shared package holds:
  - FSM state encodings: STOPPED=1'b0, RUNNING=1'b1.
  - Default timing constants: DEBOUNCE_CYCLES, RUN_PERIOD.
- One sub-module, btn_debounce_pulse: synchronizer, debounce counter, stable level and registered press pulse, parameterized by DEBOUNCE_CYCLES. It is instantiated twice, once for BtnStep and once for BtnRun.
- The top level of the block holds the FSM, divider and FetchCount.

Test Plan (bench uses DEBOUNCE_CYCLES=4, RUN_PERIOD=10, CNT_W=4):
1. Reset=0 mid-run, with BtnRun toggling -> FetchEn=0, Running=0 and FetchCount=0 immediately. After Reset=1, 20 idle cycles -> no FetchEn.
2. BtnStep high for 20 cycles, first sampled at edge 0 -> exactly one FetchEn pulse, high after edge 7. FetchCount=1. Release gives no pulse.
3. BtnStep high for 3 cycles, then low -> no FetchEn; FetchCount stays 0.
4. BtnRun press -> Running=1; FetchEn pulses 10 edges after Running rises, then every 10 edges. A BtnStep press during RUNNING adds no pulse. A second BtnRun press -> Running=0 and no further pulses over 50 cycles.
5. 17 separate step presses -> FetchCount goes 1, 2, ..., 15, 0, 1 (wrap at 16).
6. BtnStep and BtnRun raised on the same edge in STOPPED -> Running=1 and no immediate FetchEn. The first FetchEn comes 10 edges after Running rises.
